// File: rtl/axi4lite_regbank_slave.sv
// AXI4-Lite slave with four R/W registers and one read-only status word.
// Optional SLVERR responses for unmapped/RO accesses: define AXI4LITE_REGBANK_ERR_EN.
module axi4lite_regbank_slave #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic [DATA_WIDTH-1:0]     status_in,
  output logic [4*DATA_WIDTH-1:0]   reg_out
);

  localparam int unsigned NUM_REGS    = 4;
  localparam int unsigned STATUS_ADDR = 4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef AXI4LITE_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wstrb0_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_strb0;
  logic                  wr_mapped;
  logic [1:0]            wr_resp;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = (r_state == R_IDLE) && !s_axi_rvalid;
  assign reg_out       = {regs[3], regs[2], regs[1], regs[0]};

  // Write commit decode: held channel values take precedence over the live bus.
  always_comb begin
    aw_fire   = s_axi_awvalid && s_axi_awready;
    w_fire    = s_axi_wvalid && s_axi_wready;
    commit    = (w_state == W_COLLECT) && (aw_held || aw_fire) && (w_held || w_fire);
    wr_addr   = aw_held ? aw_addr_q : s_axi_awaddr;
    wr_data   = w_held ? wdata_q : s_axi_wdata;
    wr_strb0  = w_held ? wstrb0_q : s_axi_wstrb[0];
    wr_mapped = 32'(wr_addr) < NUM_REGS;
    wr_resp   = (ERR_EN && !wr_mapped) ? RESP_SLVERR : RESP_OKAY;
  end

  // Read mux samples pre-edge register contents.
  always_comb begin
    ar_fire = s_axi_arvalid && s_axi_arready;
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (32'(s_axi_araddr) < NUM_REGS) begin
      rd_data = regs[s_axi_araddr[1:0]];
    end else if (32'(s_axi_araddr) == STATUS_ADDR) begin
      rd_data = status_in;
    end else if (ERR_EN) begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Write path FSM and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_COLLECT;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      wdata_q      <= '0;
      wstrb0_q     <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (commit) begin
            if (wr_strb0 && wr_mapped) regs[wr_addr[1:0]] <= wr_data;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_resp;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            w_state      <= W_RESP;
          end else begin
            if (aw_fire) begin
              aw_held   <= 1'b1;
              aw_addr_q <= s_axi_awaddr;
            end
            if (w_fire) begin
              w_held   <= 1'b1;
              wdata_q  <= s_axi_wdata;
              wstrb0_q <= s_axi_wstrb[0];
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state      <= W_COLLECT;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Read path FSM, independent of the write path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_resp;
            s_axi_rvalid <= 1'b1;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Self-checking bench for axi4lite_regbank_slave: transaction-level model plus directed scenarios.
module tb_axi4lite_regbank_slave;

`ifdef AXI4LITE_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] ERR_RESP = ERR_EN ? 2'b10 : 2'b00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [7:0]  wdata = '0;
  logic [0:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  status_in = '0;
  logic [31:0] reg_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4lite_regbank_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .status_in(status_in), .reg_out(reg_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending AW/W, outstanding B/R responses, register array.
  logic [7:0] m_regs [4];
  bit         m_aw_pend, m_w_pend, m_bvalid, m_rvalid, started;
  logic [3:0] m_aw_addr;
  logic [7:0] m_wdata, m_rdata;
  logic       m_wstrb;
  logic [1:0] m_bresp, m_rresp;

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a < 4) return m_regs[a[1:0]];
    if (a == 4) return status_in;
    return 8'h00;
  endfunction

  // Compare the DUT against the model mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit e_awready, e_wready, e_arready;
    e_awready = !m_aw_pend && !m_bvalid;
    e_wready  = !m_w_pend && !m_bvalid;
    e_arready = !m_rvalid;
    if (started) begin
      check("awready", 32'(awready), 32'(e_awready));
      check("wready", 32'(wready), 32'(e_wready));
      check("arready", 32'(arready), 32'(e_arready));
      check("bvalid", 32'(bvalid), 32'(m_bvalid));
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      check("reg_out", reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      if (m_bvalid) check("bresp", 32'(bresp), 32'(m_bresp));
      if (m_rvalid) begin
        check("rdata", 32'(rdata), 32'(m_rdata));
        check("rresp", 32'(rresp), 32'(m_rresp));
      end
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_aw_pend = 0; m_w_pend = 0; m_bvalid = 0; m_rvalid = 0;
      started = 1;
    end else if (started) begin
      if (arvalid && e_arready) begin
        m_rvalid = 1;
        m_rdata  = m_read(araddr);
        m_rresp  = (araddr > 4) ? ERR_RESP : 2'b00;
      end else if (m_rvalid && rready) begin
        m_rvalid = 0;
      end
      if (m_bvalid) begin
        if (bready) m_bvalid = 0;
      end else begin
        if (awvalid && e_awready) begin m_aw_pend = 1; m_aw_addr = awaddr; end
        if (wvalid && e_wready) begin m_w_pend = 1; m_wdata = wdata; m_wstrb = wstrb[0]; end
        if (m_aw_pend && m_w_pend) begin
          if (m_wstrb && m_aw_addr < 4) m_regs[m_aw_addr[1:0]] = m_wdata;
          m_bresp   = (m_aw_addr >= 4) ? ERR_RESP : 2'b00;
          m_bvalid  = 1;
          m_aw_pend = 0;
          m_w_pend  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_both(input logic [3:0] a, input logic [7:0] d, input logic s);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
  endtask

  task automatic read_addr(input logic [3:0] a);
    araddr = a; arvalid = 1;
    tick();
    arvalid = 0;
  endtask

  task automatic ack_b();
    bready = 1; tick(); bready = 0;
  endtask

  task automatic ack_r();
    rready = 1; tick(); rready = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    tick();
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_reg_out", reg_out, 32'h0);

    // Simultaneous AW+W to reg2, then read it back.
    write_both(4'd2, 8'hA5, 1'b1);
    check("sim_bvalid", 32'(bvalid), 32'd1);
    check("sim_bresp", 32'(bresp), 32'd0);
    check("sim_reg2", 32'(reg_out[23:16]), 32'hA5);
    ack_b();
    check("sim_bvalid_clr", 32'(bvalid), 32'd0);
    read_addr(4'd2);
    check("sim_rvalid", 32'(rvalid), 32'd1);
    check("sim_rdata", 32'(rdata), 32'hA5);
    check("sim_rresp", 32'(rresp), 32'd0);
    ack_r();

    // W first, AW three cycles later.
    wdata = 8'h3C; wstrb = 1'b1; wvalid = 1;
    tick();
    wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      check("ooo_wready", 32'(wready), 32'd0);
      check("ooo_no_b", 32'(bvalid), 32'd0);
      tick();
    end
    check("ooo_wready", 32'(wready), 32'd0);
    awaddr = 4'd1; awvalid = 1;
    tick();
    awvalid = 0;
    check("ooo_bvalid", 32'(bvalid), 32'd1);
    check("ooo_reg1", 32'(reg_out[15:8]), 32'h3C);
    ack_b();

    // Write backpressure.
    write_both(4'd0, 8'h5C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bresp", 32'(bresp), 32'd0);
      check("bp_awready", 32'(awready), 32'd0);
      check("bp_wready", 32'(wready), 32'd0);
      tick();
    end
    ack_b();
    // Read backpressure with a second AR waiting.
    read_addr(4'd0);
    araddr = 4'd1; arvalid = 1;
    for (int i = 0; i < 4; i++) begin
      check("bp_rdata", 32'(rdata), 32'h5C);
      check("bp_arready", 32'(arready), 32'd0);
      tick();
    end
    arvalid = 0;
    ack_r();

    // Status, unmapped and read-only accesses.
    status_in = 8'h5A;
    read_addr(4'd4);
    check("stat_rdata", 32'(rdata), 32'h5A);
    check("stat_rresp", 32'(rresp), 32'd0);
    ack_r();
    read_addr(4'd7);
    check("unmap_rdata", 32'(rdata), 32'h00);
    check("unmap_rresp", 32'(rresp), 32'(ERR_RESP));
    ack_r();
    write_both(4'd4, 8'h11, 1'b1);
    check("ro_bresp", 32'(bresp), 32'(ERR_RESP));
    check("ro_reg_out", reg_out, 32'h00A53C5C);
    ack_b();
    write_both(4'd3, 8'hFF, 1'b0);
    check("strb0_bresp", 32'(bresp), 32'd0);
    check("strb0_reg_out", reg_out, 32'h00A53C5C);
    ack_b();

    // Reset with only AW collected.
    awaddr = 4'd0; awvalid = 1;
    tick();
    awvalid = 0;
    check("mid_awready_held", 32'(awready), 32'd0);
    rst = 1;
    tick();
    rst = 0;
    check("mid_awready", 32'(awready), 32'd1);
    check("mid_bvalid", 32'(bvalid), 32'd0);
    check("mid_reg_out", reg_out, 32'h0);
    wdata = 8'h99; wstrb = 1'b1; wvalid = 1;
    tick();
    wvalid = 0;
    check("mid_no_commit", 32'(bvalid), 32'd0);
    check("mid_reg_out2", reg_out, 32'h0);
    awaddr = 4'd5; awvalid = 1;
    tick();
    awvalid = 0;
    check("mid_unmap_bresp", 32'(bresp), 32'(ERR_RESP));
    check("mid_reg_out3", reg_out, 32'h0);
    ack_b();

    // Write to reg3 committing on the same edge as a read of reg3.
    awaddr = 4'd3; awvalid = 1; wdata = 8'h77; wstrb = 1'b1; wvalid = 1;
    araddr = 4'd3; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("haz_old_rdata", 32'(rdata), 32'h00);
    check("haz_reg3", 32'(reg_out[31:24]), 32'h77);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    read_addr(4'd3);
    check("haz_new_rdata", 32'(rdata), 32'h77);
    ack_r();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
